// File: rtl/lsu_pkg.sv
// +-----------------------------------------------------------------------------
// | lsu_pkg
// | Shared size encodings, FSM states and alignment helper for the load/store unit.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    // True when the access cannot be issued: illegal size or natural misalignment.
    function automatic logic lsu_access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = |addr_lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// +-----------------------------------------------------------------------------
// | lsu_lane
// | Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = word_i[7:0];
        w_half   = word_i[15:0];
        load_o   = word_i;
        merged_o = wdata_i;

        case (addr_lo_i)
            2'd0:    w_byte = word_i[7:0];
            2'd1:    w_byte = word_i[15:8];
            2'd2:    w_byte = word_i[23:16];
            default: w_byte = word_i[31:24];
        endcase

        if (addr_lo_i[1]) begin
            w_half = word_i[31:16];
        end

        case (size_i)
            SZ_BYTE: begin
                load_o   = {{24{signed_i & w_byte[7]}}, w_byte};
                merged_o = word_i;
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                load_o   = {{16{signed_i & w_half[15]}}, w_half};
                merged_o = word_i;
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0]  = wdata_i[15:0];
                end
            end
            default: begin
                load_o   = word_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +-----------------------------------------------------------------------------
// | load_store_unit
// | One-at-a-time load/store sequencer onto a word bus without byte enables.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stb,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic        mem_stb_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        w_req_err;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_req_err = lsu_access_err(req_size, req_addr[1:0]);

    // Lane logic works on captured request fields so nothing from req_* reaches an output.
    lsu_lane u_lane (
        .word_i    (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .load_o    (w_load),
        .merged_o  (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_q      <= 32'd0;
            mem_stb_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (w_req_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                            mem_stb_q  <= 1'b1;
                            if (req_we && (req_size == SZ_WORD)) begin
                                state_q     <= S_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q  <= S_READ;
                                mem_we_q <= 1'b0;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        if (we_q) begin
                            // Sub-word store: strobe stays up, bus turns straight into the write phase.
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= w_merged;
                        end else begin
                            state_q      <= S_RESP;
                            mem_stb_q    <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= w_load;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        state_q      <= S_RESP;
                        mem_stb_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_stb    = mem_stb_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +-----------------------------------------------------------------------------
// | tb_load_store_unit
// | Directed and randomized checks of load_store_unit against a word-memory model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_stb;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_stb    (mem_stb),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word-addressed memory; untouched words have a deterministic address-derived value.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        bus_log [$];
    int          cfg_waits = 0;
    bit          in_phase  = 0;
    bit          ack_real  = 0;
    int          wleft     = 0;
    bit          ph_we;
    logic [31:0] ph_addr;
    logic [31:0] ph_wdata;

    // Bus responder: ack after cfg_waits cycles per phase, noise on ack while idle.
    always @(negedge clk) begin
        if (ack_real) begin
            bus_log.push_back(bus_t'{ph_we, ph_addr, ph_wdata});
            if (ph_we) mem[ph_addr >> 2] = ph_wdata;
            in_phase = 0;
        end
        ack_real = 0;
        if (rst || !mem_stb) begin
            in_phase  = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end else begin
            if (!in_phase) begin
                in_phase = 1;
                wleft    = cfg_waits;
                ph_we    = mem_we;
                ph_addr  = mem_addr;
                ph_wdata = mem_wdata;
            end else begin
                chk("bus_addr_stable", mem_addr, ph_addr);
                chk("bus_we_stable", {31'd0, mem_we}, {31'd0, ph_we});
                if (ph_we) chk("bus_wdata_stable", mem_wdata, ph_wdata);
            end
            if (wleft == 0) begin
                mem_ack   = 1'b1;
                ack_real  = 1;
                mem_rdata = ph_we ? $urandom : memrd(ph_addr);
            end else begin
                wleft--;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          output logic [31:0] got_rd, output bit got_err, output int got_lat);
        logic [31:0] w, wa, mask, exp_rd, exp_mem;
        int          nb, sh, lat, c;
        bit          err;
        bus_t        exp_bus [$];

        w    = memrd(a);
        wa   = {a[31:2], 2'b00};
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        sh   = 8 * int'(a[1:0]);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        err  = (sz == 2'b11) || ((int'(a[1:0]) % nb) != 0);
        exp_rd  = 32'd0;
        exp_mem = (w & ~(mask << sh)) | ((wd & mask) << sh);
        if (err) begin
            lat = 1;
        end else if (!we) begin
            exp_rd = (w >> sh) & mask;
            if (sg && nb < 4 && exp_rd[8 * nb - 1]) exp_rd = exp_rd | ~mask;
            exp_bus.push_back(bus_t'{1'b0, wa, 32'd0});
            lat = 2 + waits;
        end else if (nb == 4) begin
            exp_bus.push_back(bus_t'{1'b1, wa, exp_mem});
            lat = 2 + waits;
        end else begin
            exp_bus.push_back(bus_t'{1'b0, wa, 32'd0});
            exp_bus.push_back(bus_t'{1'b1, wa, exp_mem});
            lat = 3 + 2 * waits;
        end

        cfg_waits = waits;
        @(posedge clk); #1;
        bus_log.delete();
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        // Busy-time request inputs carry garbage that must be ignored.
        req_we    = $urandom_range(0, 1);
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
        got_lat = 0;
        got_rd  = 32'd0;
        got_err = 0;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp_valid && got_lat == 0) begin
                got_lat = c;
                got_rd  = resp_rdata;
                got_err = resp_err;
            end
            chk("resp_valid_cycle", {31'd0, resp_valid}, {31'd0, (c == lat)});
            chk("req_ready_cycle", {31'd0, req_ready}, {31'd0, (c > lat)});
            if (err) chk("no_stb_on_err", {31'd0, mem_stb}, 32'd0);
            if (mem_stb) chk("mem_addr", mem_addr, wa);
            if (c > lat && (got_lat != 0 || c > lat + 2)) break;
        end
        req_valid = 1'b0;
        chk("latency", got_lat, lat);
        chk("resp_rdata", got_rd, exp_rd);
        chk("resp_err", {31'd0, got_err}, {31'd0, err});
        chk("bus_count", bus_log.size(), exp_bus.size());
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
            chk("bus_we", {31'd0, bus_log[i].we}, {31'd0, exp_bus[i].we});
            chk("bus_addr", bus_log[i].addr, exp_bus[i].addr);
            if (exp_bus[i].we) chk("bus_wdata", bus_log[i].data, exp_bus[i].data);
        end
        if (!err && we) chk("mem_after_store", memrd(a), exp_mem);
    endtask

    logic [31:0] rd;
    bit          er;
    int          lt;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_stb", {31'd0, mem_stb}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem[32'h100 >> 2] = 32'h8765_4321;
        do_req(0, 2'b01, 1, 32'h0000_0102, 32'd0, 0, rd, er, lt);
        chk("lit_lh_signed", rd, 32'hFFFF_8765);
        chk("lit_lh_lat", lt, 2);

        mem[32'h200 >> 2] = 32'h80AA_BBCC;
        do_req(0, 2'b00, 0, 32'h0000_0203, 32'd0, 1, rd, er, lt);
        chk("lit_lbu", rd, 32'h0000_0080);
        do_req(0, 2'b00, 1, 32'h0000_0203, 32'd0, 0, rd, er, lt);
        chk("lit_lb", rd, 32'hFFFF_FF80);

        mem[32'h300 >> 2] = 32'h1122_3344;
        do_req(1, 2'b00, 0, 32'h0000_0301, 32'h1234_565A, 0, rd, er, lt);
        chk("lit_sb_mem", mem[32'h300 >> 2], 32'h1122_5A44);
        chk("lit_sb_lat", lt, 3);
        mem[32'h300 >> 2] = 32'h1122_3344;
        do_req(1, 2'b00, 0, 32'h0000_0301, 32'h0000_005A, 2, rd, er, lt);
        chk("lit_sb_wait_lat", lt, 7);
        chk("lit_sb_wait_mem", mem[32'h300 >> 2], 32'h1122_5A44);

        do_req(1, 2'b01, 0, 32'h0000_0401, 32'hFFFF_FFFF, 0, rd, er, lt);
        chk("lit_sh_err", {31'd0, er}, 32'd1);
        chk("lit_sh_err_lat", lt, 1);
        do_req(0, 2'b10, 0, 32'h0000_0402, 32'd0, 0, rd, er, lt);
        chk("lit_lw_err", {31'd0, er}, 32'd1);

        do_req(1, 2'b10, 0, 32'h0000_0500, 32'hDEAD_BEEF, 0, rd, er, lt);
        chk("lit_sw_mem", mem[32'h500 >> 2], 32'hDEAD_BEEF);
        chk("lit_sw_lat", lt, 2);
        chk("lit_sw_rdata", rd, 32'd0);

        // Reset in the middle of a read wait-state.
        cfg_waits = 6;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_read_stb", {31'd0, mem_stb}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stb", {31'd0, mem_stb}, 32'd0);
        chk("async_rst_we", {31'd0, mem_we}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem[32'h600 >> 2] = 32'hCAFE_F00D;
        do_req(0, 2'b10, 0, 32'h0000_0600, 32'd0, 1, rd, er, lt);
        chk("after_rst_load", rd, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                   32'h0000_1000 + 32'($urandom_range(0, 47)), $urandom,
                   $urandom_range(0, 3), rd, er, lt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
